// File: rtl/lut_cfg_chain_driver.sv
// lut_cfg_chain_driver
//
// Upstream sequencer for a latch-based LUT configuration chain. A frame word
// is accepted over a valid/ready handshake and its low N_BITS bits are shifted
// MSB-first onto CONFin. Every bit is framed by two non-overlapping,
// non-adjacent latch-enable pulses: PHA (even latches) then PHB (odd latches).
//
// Optional feature macro: LUT_CFG_READBACK_EN
//   defined   : CONFout_tail is sampled once per bit into rb_data
//   undefined : rb_data is tied to 0 and CONFout_tail is ignored
//
// Ports
//   CLK           sole clock, rising edge
//   RESETn        asynchronous active-low reset
//   in_data       frame word (bits DATA_WIDTH-1..N_BITS ignored)
//   in_valid      frame word offered
//   in_ready      driver can accept a word (IDLE)
//   CONFin        serial data to the chain head
//   PHA / PHB     even / odd latch enables
//   CONFout_tail  chain tail, used for readback
//   busy          frame in progress
//   done          one-cycle pulse in the last cycle of a frame
//   rb_data       readback word, valid while done=1

module lut_cfg_chain_driver #(
    parameter int DATA_WIDTH = 32,
    parameter int N_BITS     = 18,
    parameter int PULSE_CYC  = 1,
    parameter int GAP_CYC    = 1
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  CONFin,
    output logic                  PHA,
    output logic                  PHB,
    input  logic                  CONFout_tail,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rb_data
);

    localparam int TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int CNT_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_A_HI   = 3'd2;
    localparam logic [2:0] S_A_GAP  = 3'd3;
    localparam logic [2:0] S_B_HI   = 3'd4;
    localparam logic [2:0] S_B_GAP  = 3'd5;
    localparam logic [2:0] S_FINISH = 3'd6;

    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(N_BITS - 1);

    logic [2:0]        state, state_nxt;
    logic [TMR_W-1:0]  tmr, tmr_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [N_BITS-1:0] shreg;
    logic              accept;
    logic              last_gap;

    // Bits above N_BITS never reach the chain.
    logic unused_in_data;
    assign unused_in_data = ^in_data;

    // NOTE: every signal assigned here gets a default at the top, so no path
    // through the case statement can leave a value held and infer a latch.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        last_gap  = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                tmr_nxt   = PULSE_LOAD;
                state_nxt = S_A_HI;
            end
            S_A_HI: begin
                if (tmr == '0) begin
                    tmr_nxt   = GAP_LOAD;
                    state_nxt = S_A_GAP;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            S_A_GAP: begin
                if (tmr == '0) begin
                    tmr_nxt   = PULSE_LOAD;
                    state_nxt = S_B_HI;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            S_B_HI: begin
                if (tmr == '0) begin
                    tmr_nxt   = GAP_LOAD;
                    state_nxt = S_B_GAP;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            S_B_GAP: begin
                if (tmr == '0) begin
                    last_gap = 1'b1;
                    if (cnt == '0) begin
                        state_nxt = S_FINISH;
                    end else begin
                        cnt_nxt   = cnt - 1'b1;
                        state_nxt = S_SETUP;
                    end
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered copies of a decode of the next state, so each
    // output is already correct in the first cycle of its state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= S_IDLE;
            tmr      <= '0;
            cnt      <= '0;
            shreg    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            PHA      <= 1'b0;
            PHB      <= 1'b0;
            CONFin   <= 1'b0;
        end else begin
            state    <= state_nxt;
            tmr      <= tmr_nxt;
            cnt      <= cnt_nxt;
            in_ready <= (state_nxt == S_IDLE);
            busy     <= (state_nxt != S_IDLE);
            done     <= (state_nxt == S_FINISH);
            PHA      <= (state_nxt == S_A_HI);
            PHB      <= (state_nxt == S_B_HI);
            // CONFin changes only on entry to SETUP, holding through B_GAP.
            if (accept) begin
                shreg  <= in_data[N_BITS-1:0];
                CONFin <= in_data[N_BITS-1];
            end else if (last_gap && (cnt != '0)) begin
                CONFin <= shreg[cnt_nxt];
            end
        end
    end

`ifdef LUT_CFG_READBACK_EN
    // The tail shows the oldest resident bit first, so after N_BITS samples
    // that bit sits at position N_BITS-1.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rb_data <= '0;
        end else if (accept) begin
            rb_data <= '0;
        end else if (last_gap) begin
            rb_data <= {rb_data[DATA_WIDTH-2:0], CONFout_tail};
        end
    end
`else
    logic unused_tail;
    assign unused_tail = CONFout_tail;
    assign rb_data     = '0;
`endif

endmodule

// File: tb/tb_lut_cfg_chain_driver.sv
// Testbench for lut_cfg_chain_driver. Two instances share clock and reset:
// d0 with default parameters and d1 with N_BITS=4, PULSE_CYC=3, GAP_CYC=2.
// Expected waveforms are computed per cycle from the bit index and offset
// within the bit period; readback uses a behavioural chain model on d0.

module tb_lut_cfg_chain_driver;

    localparam int DW = 32;
    localparam int N0 = 18, P0 = 1, G0 = 1;
    localparam int N1 = 4,  P1 = 3, G1 = 2;

    logic          CLK = 1'b0;
    logic          RESETn = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    bit            sel = 1'b0;

    logic          valid0, valid1;
    logic          ready0, confin0, pha0, phb0, busy0, done0;
    logic          ready1, confin1, pha1, phb1, busy1, done1;
    logic [DW-1:0] rb0, rb1;

    logic          o_ready, o_confin, o_pha, o_phb, o_busy, o_done;

    int n_cmp = 0;
    int n_mis = 0;
    int last_wait;

    // Behavioural chain: shifts once per PHB pulse; the tail presents the
    // bit shifted out, i.e. the oldest resident bit is seen first.
    logic [N0-1:0] chain = '0;
    logic          chain_out = 1'b0;
    logic          phb_d = 1'b0;
    bit            preload_req = 1'b0;
    logic [N0-1:0] preload_val = '0;

    always #5 CLK = ~CLK;

    assign valid0 = in_valid & ~sel;
    assign valid1 = in_valid & sel;

    assign o_ready  = sel ? ready1  : ready0;
    assign o_confin = sel ? confin1 : confin0;
    assign o_pha    = sel ? pha1    : pha0;
    assign o_phb    = sel ? phb1    : phb0;
    assign o_busy   = sel ? busy1   : busy0;
    assign o_done   = sel ? done1   : done0;

    lut_cfg_chain_driver #(.DATA_WIDTH(DW), .N_BITS(N0), .PULSE_CYC(P0), .GAP_CYC(G0)) d0 (
        .CLK(CLK), .RESETn(RESETn), .in_data(in_data), .in_valid(valid0),
        .in_ready(ready0), .CONFin(confin0), .PHA(pha0), .PHB(phb0),
        .CONFout_tail(chain_out), .busy(busy0), .done(done0), .rb_data(rb0)
    );

    lut_cfg_chain_driver #(.DATA_WIDTH(DW), .N_BITS(N1), .PULSE_CYC(P1), .GAP_CYC(G1)) d1 (
        .CLK(CLK), .RESETn(RESETn), .in_data(in_data), .in_valid(valid1),
        .in_ready(ready1), .CONFin(confin1), .PHA(pha1), .PHB(phb1),
        .CONFout_tail(1'b0), .busy(busy1), .done(done1), .rb_data(rb1)
    );

    always @(posedge CLK) begin
        phb_d <= phb0;
        if (preload_req) begin
            chain <= preload_val;
        end else if (phb0 && !phb_d) begin
            chain_out <= chain[N0-1];
            chain     <= {chain[N0-2:0], confin0};
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge CLK);
        check({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
        check({tag, "_busy"},  {31'd0, o_busy},  32'd0);
        check({tag, "_phase"}, {30'd0, o_pha, o_phb}, 32'd0);
        check({tag, "_done"},  {31'd0, o_done},  32'd0);
    endtask

    // Offer word w and follow the frame cycle by cycle. Cycle 1 is SETUP.
    // abort_cyc>0 returns after that cycle has been checked. With chain set,
    // in_valid stays high and in_data switches to w2 after acceptance.
    task automatic do_frame(input logic [DW-1:0] w, input int abort_cyc,
                            input bit chain_nxt, input logic [DW-1:0] w2);
        int n, p, g, pb, lat, waits, off, bi;
        logic prev_a, prev_b, exp_a, exp_b;
        n = sel ? N1 : N0;
        p = sel ? P1 : P0;
        g = sel ? G1 : G0;
        pb  = 1 + 2 * p + 2 * g;
        lat = n * pb + 1;
        in_data  = w;
        in_valid = 1'b1;
        waits = 0;
        while (o_ready !== 1'b1 && waits < 200) begin
            @(negedge CLK);
            waits++;
        end
        last_wait = waits;
        check("ready_before_accept", {31'd0, o_ready}, 32'd1);
        prev_a = 1'b0;
        prev_b = 1'b0;
        for (int cyc = 1; cyc <= lat; cyc++) begin
            @(negedge CLK);
            if (cyc == 1) begin
                if (chain_nxt) in_data = w2;
                else in_valid = 1'b0;
            end
            off = (cyc - 1) % pb;
            bi  = (cyc - 1) / pb;
            exp_a = (cyc < lat) && (off >= 1) && (off <= p);
            exp_b = (cyc < lat) && (off >= 1 + p + g) && (off <= 2 * p + g);
            check($sformatf("busy_c%0d", cyc),  {31'd0, o_busy},  32'd1);
            check($sformatf("ready_c%0d", cyc), {31'd0, o_ready}, 32'd0);
            check($sformatf("pha_c%0d", cyc),   {31'd0, o_pha},   {31'd0, exp_a});
            check($sformatf("phb_c%0d", cyc),   {31'd0, o_phb},   {31'd0, exp_b});
            check($sformatf("done_c%0d", cyc),  {31'd0, o_done},  {31'd0, cyc == lat});
            if (cyc < lat)
                check($sformatf("confin_c%0d", cyc), {31'd0, o_confin}, {31'd0, w[n - 1 - bi]});
            check($sformatf("phase_sep_c%0d", cyc),
                  {31'd0, (o_pha & o_phb) | (o_pha & prev_b) | (o_phb & prev_a)}, 32'd0);
            prev_a = o_pha;
            prev_b = o_phb;
            if (cyc == abort_cyc) return;
        end
    endtask

    initial begin
        logic [DW-1:0] r, w1, w2, exp_rb;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_ready0", {31'd0, ready0}, 32'd0);
        check("rst_ready1", {31'd0, ready1}, 32'd0);
        check("rst_outs0", {27'd0, confin0, pha0, phb0, busy0, done0}, 32'd0);
        check("rst_outs1", {27'd0, confin1, pha1, phb1, busy1, done1}, 32'd0);
        check("rst_rb0", rb0, 32'd0);
        RESETn = 1'b1;
        @(negedge CLK);
        check("post_rst_ready0", {31'd0, ready0}, 32'd1);
        check("post_rst_ready1", {31'd0, ready1}, 32'd1);
        repeat (3) idle_check("idle0");

        // Defaults, alternating pattern with random ignored upper bits
        r = $urandom();
        w1 = (r & 32'hFFFC_0000) | 32'h0002_AAAA;
        do_frame(w1, 0, 1'b0, '0);
        idle_check("after_aaaa");

        // Random words on the default instance
        for (int k = 0; k < 3; k++) begin
            w1 = $urandom();
            do_frame(w1, 0, 1'b0, '0);
            idle_check("after_rand0");
        end

        // Slow-phase instance
        sel = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w1 = $urandom();
            do_frame(w1, 0, 1'b0, '0);
            idle_check("after_rand1");
        end

        // in_valid held high across two words: second taken only after FINISH
        w1 = $urandom();
        w2 = $urandom();
        do_frame(w1, 0, 1'b1, w2);
        do_frame(w2, 0, 1'b0, '0);
        check("b2b_idle_gap", last_wait, 32'd1);
        idle_check("after_b2b");
        sel = 1'b0;

        // Reset during the 7th A_HI (cycle 6*5+2)
        w1 = $urandom();
        do_frame(w1, 32, 1'b0, '0);
        #2 RESETn = 1'b0;
        #1;
        check("mid_rst_pha", {31'd0, pha0}, 32'd0);
        check("mid_rst_confin", {31'd0, confin0}, 32'd0);
        check("mid_rst_busy", {31'd0, busy0}, 32'd0);
        check("mid_rst_ready", {31'd0, ready0}, 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);
        check("mid_rst_ready_back", {31'd0, ready0}, 32'd1);
        w1 = $urandom();
        do_frame(w1, 0, 1'b0, '0);
        idle_check("after_mid_rst");

        // Readback: preload the chain, load zeros, then chained reloads
        preload_val = 18'h2_5A5A;
        preload_req = 1'b1;
        @(negedge CLK);
        preload_req = 1'b0;
        do_frame(32'h0, 0, 1'b0, '0);
`ifdef LUT_CFG_READBACK_EN
        exp_rb = 32'h0002_5A5A;
`else
        exp_rb = 32'h0;
`endif
        check("rb_preload", rb0, exp_rb);
        idle_check("after_rb0");
        w1 = $urandom();
        do_frame(w1, 0, 1'b0, '0);
`ifdef LUT_CFG_READBACK_EN
        exp_rb = 32'h0;
`else
        exp_rb = 32'h0;
`endif
        check("rb_zero_frame", rb0, exp_rb);
        idle_check("after_rb1");
        w2 = $urandom();
        do_frame(w2, 0, 1'b0, '0);
`ifdef LUT_CFG_READBACK_EN
        exp_rb = w1 & 32'h0003_FFFF;
`else
        exp_rb = 32'h0;
`endif
        check("rb_prev_word", rb0, exp_rb);
        idle_check("after_rb2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
